// File: rtl/hs_arb_pkg.sv
// Shared definitions for the handshake transmit arbiter.
// Optional build macro HS_ARB_ID_TAG_EN prepends the winner index to Hs_Data.
package hs_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    WAIT  = 2'b10
  } arbState_t;

`ifdef HS_ARB_ID_TAG_EN
  localparam bit ID_TAG_EN = 1'b1;
`else
  localparam bit ID_TAG_EN = 1'b0;
`endif

  localparam int WID_DATA_DEF = 8;
  localparam int WID_ID_DEF   = 2;

  // Width of the word handed to the handshake channel.
  function automatic int hsDataW(int widData, int widId);
    return widData + (ID_TAG_EN ? widId : 0);
  endfunction

  localparam int HS_DATA_W = hsDataW(WID_DATA_DEF, WID_ID_DEF);

endpackage

// File: rtl/hs_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: rotate the request vector so the search
// starts just after Last, then take the lowest set bit.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int WID_ID  = 2
) (
  input  logic [NUM_REQ-1:0] Req,
  input  logic [WID_ID-1:0]  Last,
  output logic               Valid,
  output logic [WID_ID-1:0]  Index
);

  always_comb begin
    int base;
    logic [NUM_REQ-1:0] rot;
    base  = (int'(Last) + 1) % NUM_REQ;
    rot   = NUM_REQ'({Req, Req} >> base);
    Valid = |Req;
    Index = '0;
    // Descending scan so the lowest rotated position wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) Index = WID_ID'((base + i) % NUM_REQ);
    end
  end

endmodule

// File: rtl/hs_tx_arbiter.sv
// Round-robin scheduler sharing one CDC handshake channel among NUM_REQ sources.
// Define HS_ARB_ID_TAG_EN to send {winner index, payload} on Hs_Data.
module hs_tx_arbiter
  import hs_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int WID_DATA = 8,
  parameter int WID_ID   = 2
) (
  input  logic                                  T_Clock,
  input  logic                                  T_Reset,
  input  logic [NUM_REQ-1:0]                    Req,
  input  logic [NUM_REQ*WID_DATA-1:0]           Data,
  output logic [NUM_REQ-1:0]                    Ack,
  output logic                                  Hs_Start,
  output logic [hsDataW(WID_DATA, WID_ID)-1:0]  Hs_Data,
  input  logic                                  Hs_Busy,
  output logic [WID_ID-1:0]                     Owner,
  output logic                                  Active
);

  arbState_t          state, stateNxt;
  logic [WID_ID-1:0]  last;
  logic [WID_ID-1:0]  pickIdx;
  logic               pickVld;
  logic               grant;
  logic [WID_DATA-1:0] payload;

  rr_pick #(.NUM_REQ(NUM_REQ), .WID_ID(WID_ID)) uPick (
    .Req   (Req),
    .Last  (last),
    .Valid (pickVld),
    .Index (pickIdx)
  );

  // Only IDLE looks at requests; a still-busy channel blocks the grant.
  assign grant = (state == IDLE) && pickVld && !Hs_Busy;

  always_comb begin
    payload = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pickIdx == WID_ID'(i)) payload = Data[i*WID_DATA +: WID_DATA];
    end
  end

  always_ff @(posedge T_Clock or negedge T_Reset) begin
    if (!T_Reset) state <= IDLE;
    else          state <= stateNxt;
  end

  always_comb begin
    stateNxt = IDLE;
    Hs_Start = 1'b0;
    Ack      = '0;
    Active   = 1'b0;
    case (state)
      IDLE:  stateNxt = grant ? START : IDLE;
      START: begin
        stateNxt = WAIT;
        Hs_Start = 1'b1;
        Ack      = NUM_REQ'(1) << Owner;
        Active   = 1'b1;
      end
      WAIT: begin
        stateNxt = Hs_Busy ? WAIT : IDLE;
        Active   = 1'b1;
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge T_Clock or negedge T_Reset) begin
    if (!T_Reset) begin
      last    <= WID_ID'(NUM_REQ - 1);
      Owner   <= '0;
      Hs_Data <= '0;
    end else if (grant) begin
      last  <= pickIdx;
      Owner <= pickIdx;
`ifdef HS_ARB_ID_TAG_EN
      Hs_Data <= {pickIdx, payload};
`else
      Hs_Data <= payload;
`endif
    end
  end

endmodule

// File: tb/tb_hs_tx_arbiter.sv
// Randomized + directed bench for hs_tx_arbiter against a transaction-level model.
module tb_hs_tx_arbiter;
  import hs_arb_pkg::*;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int IW  = 2;
  localparam int HDW = hsDataW(DW, IW);

  logic            T_Clock = 1'b0;
  logic            T_Reset = 1'b1;
  logic [N-1:0]    Req     = '0;
  logic [N*DW-1:0] Data    = '0;
  logic [N-1:0]    Ack;
  logic            Hs_Start;
  logic [HDW-1:0]  Hs_Data;
  logic            Hs_Busy = 1'b0;
  logic [IW-1:0]   Owner;
  logic            Active;

  always #5 T_Clock = ~T_Clock;

  hs_tx_arbiter #(.NUM_REQ(N), .WID_DATA(DW), .WID_ID(IW)) dut (
    .T_Clock  (T_Clock),
    .T_Reset  (T_Reset),
    .Req      (Req),
    .Data     (Data),
    .Ack      (Ack),
    .Hs_Start (Hs_Start),
    .Hs_Data  (Hs_Data),
    .Hs_Busy  (Hs_Busy),
    .Owner    (Owner),
    .Active   (Active)
  );

  int errCnt = 0;
  int chkCnt = 0;

  // Reference model: one outstanding transfer at a time, round-robin pointer.
  int             mLast;
  int             mOwner;
  logic [HDW-1:0] mData;
  bit             mInFlight;
  bit             mStart;
  // Channel emulation: busy for busyLen cycles after each start pulse.
  int             busyCnt = 0;
  int             busyLen = 6;
  bit             forceBusy = 1'b0;
  int             obsQ[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [HDW-1:0] expWord(int idx, logic [DW-1:0] p);
    logic [31:0] w;
    w = (32'(idx) << DW) | 32'(p);
    return HDW'(w);
  endfunction

  task automatic resetModel();
    mLast     = N - 1;
    mOwner    = 0;
    mData     = '0;
    mInFlight = 1'b0;
    mStart    = 1'b0;
    busyCnt   = 0;
    Hs_Busy   = forceBusy;
  endtask

  task automatic modelEdge();
    int win;
    bit found;
    if (!mInFlight) begin
      if (Req != '0 && !Hs_Busy) begin
        win = 0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          int idx;
          idx = (mLast + k) % N;
          if (!found && Req[idx]) begin
            win = idx;
            found = 1'b1;
          end
        end
        mLast     = win;
        mOwner    = win;
        mData     = expWord(win, Data[win*DW +: DW]);
        mInFlight = 1'b1;
        mStart    = 1'b1;
      end
    end else if (mStart) begin
      mStart = 1'b0;
    end else if (!Hs_Busy) begin
      mInFlight = 1'b0;
    end
  endtask

  task automatic step();
    logic hsPrev;
    hsPrev = Hs_Start;
    modelEdge();
    @(posedge T_Clock);
    #1;
    if (hsPrev) busyCnt = busyLen;
    else if (busyCnt > 0) busyCnt--;
    Hs_Busy = (busyCnt != 0) || forceBusy;
    if (Hs_Start) obsQ.push_back(int'(Owner));
    chk("hs_start", 32'(Hs_Start), 32'(mStart));
    chk("ack", 32'(Ack), mStart ? (32'd1 << mOwner) : 32'd0);
    chk("active", 32'(Active), 32'(mInFlight));
    chk("owner", 32'(Owner), 32'(mOwner));
    chk("hs_data", 32'(Hs_Data), 32'(mData));
    chk("ack_vs_busy", 32'((Ack != '0) && Hs_Busy), 32'd0);
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 60 && mInFlight; i++) step();
    chk("idle_reached", 32'(Active), 32'd0);
  endtask

  task automatic pulseReset();
    #2 T_Reset = 1'b0;
    #1;
    chk("rst_ack", 32'(Ack), 32'd0);
    chk("rst_start", 32'(Hs_Start), 32'd0);
    chk("rst_active", 32'(Active), 32'd0);
    chk("rst_owner", 32'(Owner), 32'd0);
    chk("rst_data", 32'(Hs_Data), 32'd0);
    resetModel();
    @(posedge T_Clock);
    #1 T_Reset = 1'b1;
  endtask

  initial begin
    int expOrd[5];
    expOrd = '{0, 1, 2, 3, 0};
    resetModel();

    // Power-on reset
    #2 T_Reset = 1'b0;
    #2;
    chk("por_ack", 32'(Ack), 32'd0);
    chk("por_start", 32'(Hs_Start), 32'd0);
    chk("por_data", 32'(Hs_Data), 32'd0);
    chk("por_owner", 32'(Owner), 32'd0);
    chk("por_active", 32'(Active), 32'd0);
    @(posedge T_Clock);
    #1 T_Reset = 1'b1;

    // First grant goes to requester 0 one cycle after request
    Req = 4'b0001;
    Data[7:0] = 8'hA5;
    step();
    chk("t1_start", 32'(Hs_Start), 32'd1);
    chk("t1_ack", 32'(Ack), 32'b0001);
    chk("t1_data", 32'(Hs_Data), 32'h0A5);
    chk("t1_owner", 32'(Owner), 32'd0);
    Req = '0;
    waitIdle();

    // All requesting, busy 6 cycles: order 0,1,2,3,0
    pulseReset();
    busyLen = 6;
    obsQ.delete();
    Req = 4'b1111;
    for (int i = 0; i < 150 && obsQ.size() < 5; i++) step();
    Req = '0;
    waitIdle();
    chk("t2_count", 32'(obsQ.size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < obsQ.size()) chk("t2_order", 32'(obsQ[k]), 32'(expOrd[k]));
    end

    // Busy already high in IDLE blocks the grant
    forceBusy = 1'b1;
    Hs_Busy = 1'b1;
    Req = 4'b0100;
    repeat (4) begin
      step();
      chk("t3_hold", 32'(Hs_Start), 32'd0);
    end
    forceBusy = 1'b0;
    Hs_Busy = (busyCnt != 0);
    step();
    chk("t3_start", 32'(Hs_Start), 32'd1);
    chk("t3_owner", 32'(Owner), 32'd2);
    Req = '0;
    waitIdle();

    // Last=2, Req=0011: wrap-around picks 0
    Req = 4'b0011;
    step();
    chk("t4_owner", 32'(Owner), 32'd0);
    chk("t4_tag", 32'(Hs_Data >> DW), 32'd0);
    Req = '0;
    step();

    // One-cycle request during WAIT is lost
    Req = 4'b0010;
    step();
    Req = '0;
    waitIdle();
    repeat (8) begin
      step();
      chk("t5_noack", 32'(Ack), 32'd0);
    end

    // Reset in WAIT, then Req=1000 wins first
    Req = 4'b0100;
    step();
    Req = '0;
    step();
    chk("t6_inwait", 32'(Active), 32'd1);
    pulseReset();
    Req = 4'b1000;
    step();
    chk("t6_owner", 32'(Owner), 32'd3);
    chk("t6_ack", 32'(Ack), 32'b1000);
    Req = '0;
    waitIdle();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      busyLen = $urandom_range(1, 6);
      step();
      for (int i = 0; i < N; i++) begin
        if (mStart && mOwner == i) begin
          Req[i] = 1'($urandom_range(0, 1));
          Data[i*DW +: DW] = DW'($urandom);
        end else if (!Req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            Req[i] = 1'b1;
            Data[i*DW +: DW] = DW'($urandom);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          Req[i] = 1'b0;
        end
      end
      if (!mInFlight && $urandom_range(0, 19) == 0) forceBusy = 1'b1;
      else if (forceBusy && $urandom_range(0, 2) == 0) forceBusy = 1'b0;
      Hs_Busy = (busyCnt != 0) || forceBusy;
    end
    Req = '0;
    forceBusy = 1'b0;
    Hs_Busy = (busyCnt != 0);
    waitIdle();

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule

// File: doc/hs_tx_arbiter.md
Name: hs_tx_arbiter

Overview:
- Transmit-side scheduler that shares one clock-domain-crossing handshake channel among NUM_REQ requesters in the T_Clock domain.
- Round-robin arbitration: latches the winner's data, issues a one-cycle start pulse to the handshake channel, then holds off further grants until the channel's busy flag clears.
- Sits between peripheral sources (UART RX, key scanner, timers) and the single handshake instance feeding the receive domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WID_DATA, 8, payload width per requester.
- WID_ID, 2, requester index width; must satisfy 2**WID_ID >= NUM_REQ.

Ports:
- T_Clock  input  1  transmit-domain clock.
- T_Reset  input  1  reset, asynchronous, active-low.
- Req  input  NUM_REQ  per-requester level request; held high with data stable until Ack.
- Data  input  NUM_REQ*WID_DATA  packed payloads; requester i occupies bits [i*WID_DATA +: WID_DATA].
- Ack  output  NUM_REQ  one-cycle pulse: payload captured; requester may drop Req or change Data.
- Hs_Start  output  1  one-cycle start pulse to the handshake channel.
- Hs_Data  output  see Optional Feature  registered payload to the handshake channel, stable from Hs_Start until next grant.
- Hs_Busy  input  1  handshake channel busy flag; registered by the channel, rises the cycle after Hs_Start.
- Owner  output  WID_ID  index of the last granted requester.
- Active  output  1  high from grant until Hs_Busy clears.

Behaviour:
- Reset values (all asynchronous on T_Reset low):
  - Ack=0, Hs_Start=0, Hs_Data=0, Owner=0, Active=0.
  - State=IDLE.
  - Priority pointer Last=NUM_REQ-1, so requester 0 wins first after reset.
- IDLE:
  - Grant condition: at least one Req high and Hs_Busy=0.
  - Winner: first asserted Req searching from index (Last+1) mod NUM_REQ upward, with wrap-around.
  - At the clock edge: latch Hs_Data, set Last=Owner=winner, set Active=1, go to START.
  - If the condition is not met, stay in IDLE.
- START (exactly one cycle):
  - Hs_Start=1 and Ack[Owner]=1; all other Ack bits are 0.
  - Unconditionally go to WAIT.
- WAIT:
  - Hs_Start=0.
  - Stay while Hs_Busy=1.
  - On Hs_Busy=0, go to IDLE and clear Active at that edge.
  - The first WAIT cycle always sees Hs_Busy=1 because the channel registers busy from Hs_Start.
- Latency:
  - Req high in cycle n while IDLE and Hs_Busy=0 gives Hs_Start and Ack in cycle n+1.
  - Next grant comes no earlier than the first IDLE cycle after Hs_Busy falls.
- Hs_Busy already high in IDLE (channel still finishing): no grant; wait in IDLE.
- Req deasserted before grant: request is lost, never acked. Legal.
- Req deasserted in the Ack cycle or later: no effect on the transfer.
- Req re-asserted immediately after Ack: competes normally; it loses to any other pending requester because of the pointer.
- A single persistent requester is granted back-to-back, one transfer per handshake round trip.
- Only IDLE evaluates Req; requests arriving in START or WAIT wait for IDLE.
- Reset mid-transfer: outputs and state clear immediately.
  - The channel is reset by the same T_Reset, so there is no orphan busy flag.
  - The receive side may still see one final toggle; the receive domain discards it per its own reset.
- State encoding: IDLE=2'b00, START=2'b01, WAIT=2'b10. The illegal code 2'b11 returns to IDLE with Active=0.

Optional Feature:
- Macro: HS_ARB_ID_TAG_EN.
- When defined:
  - Hs_Data is WID_ID+WID_DATA bits wide: {winner index, payload}.
  - The receive side demultiplexes on the upper WID_ID bits.
- When undefined:
  - Hs_Data is WID_DATA bits wide, payload only.
  - Owner remains the only source indication (transmit domain only).
- Arbitration and timing are identical in both builds.

Decomposition:
- Shared package hs_arb_pkg:
  - State encoding constants (IDLE, START, WAIT).
  - Localparam HS_DATA_W, computed from WID_DATA, WID_ID and HS_ARB_ID_TAG_EN.
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: Req, Last. Outputs: Valid, Index.
  - Implemented as a double-width rotate plus priority encode.
  - Reusable by future bus arbiters.

Test Plan:
- After reset, Req=4'b0001, Data0=8'hA5:
  - Next cycle: Hs_Start=1, Ack=4'b0001, Hs_Data=8'hA5, Owner=0.
  - With ID tag: Hs_Data=10'h0A5.
- Req=4'b1111 held, busy model of 6 cycles:
  - Grant order 0,1,2,3,0.
  - Exactly one Hs_Start per busy period.
  - Ack never overlaps busy-high cycles.
- Hs_Busy forced high in IDLE with Req=4'b0100:
  - No Hs_Start until Hs_Busy falls.
  - Grant to requester 2 one cycle after busy is first observed low in IDLE.
- Last=2, Req=4'b0011:
  - Wrap-around picks requester 0 before 1.
  - With tag, Hs_Data[9:8]=2'b00.
- Req pulsed high one cycle while in WAIT, then dropped: no Ack, no Hs_Start for that requester.
- T_Reset asserted during WAIT:
  - Ack, Hs_Start and Active go to 0 immediately; Owner=0.
  - After release with Req=4'b1000, the first grant goes to requester 3 via Last reset to 3.
